// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller and its datapath muxes.
// Includes the opcode/funct to instruction-class decode used by mc_ctrl.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_ABS  = 2'b10;

   localparam logic [1:0] NPCIMM_EXT = 2'b00;
   localparam logic [1:0] NPCIMM_IDX = 2'b01;
   localparam logic [1:0] NPCIMM_RD1 = 2'b10;

   localparam logic [1:0] A3_RT    = 2'b00;
   localparam logic [1:0] A3_RD    = 2'b01;
   localparam logic [1:0] A3_RA    = 2'b10;

   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_DM    = 2'b01;
   localparam logic [1:0] WD_EXT   = 2'b10;
   localparam logic [1:0] WD_PC4   = 2'b11;

   localparam logic       ALUB_EXT = 1'b0;
   localparam logic       ALUB_RD2 = 1'b1;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_J, C_JR, C_ILL
   } iclass_t;

   function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
      iclass_t c;
      c = C_ILL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU: c = C_ADDU;
               FN_SUBU: c = C_SUBU;
               FN_JR:   c = C_JR;
               default: c = C_ILL;
            endcase
         end
         OP_ORI:  c = C_ORI;
         OP_LW:   c = C_LW;
         OP_SW:   c = C_SW;
         OP_BEQ:  c = C_BEQ;
         OP_LUI:  c = C_LUI;
         OP_JAL:  c = C_JAL;
         OP_J:    c = C_J;
         default: c = C_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath selects.
// Define MC_CTRL_RETIRE_CNT_EN to add the retire_cnt output (count of PC writes).
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        PCWr,
   output logic        IRWr,
   output logic        GRFWr,
   output logic        DMWr,
   output logic [1:0]  NPCOp,
   output logic [1:0]  NPCIMM_MUXOp,
   output logic [1:0]  GRFA3_MUXOp,
   output logic [1:0]  GRFWD_MUXOp,
   output logic        ALUB_MUXOp,
   output logic [2:0]  ALUOp,
   output logic [1:0]  EXTOp,
   output logic [2:0]  state
`ifdef MC_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   localparam logic [3:0] MEM_INIT = 4'(MEM_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_mem_cnt;
   iclass_t    w_cls;

   logic       w_pcwr, w_irwr, w_grfwr, w_dmwr;
   logic [1:0] w_npcop, w_npcimm, w_a3, w_wd, w_extop;
   logic       w_alub;
   logic [2:0] w_aluop;

   assign w_cls = decode_class(opcode, funct);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_mem_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_EXEC && w_next == S_MEM)
            r_mem_cnt <= MEM_INIT;
         else if (r_state == S_MEM && r_mem_cnt != 4'd0)
            r_mem_cnt <= r_mem_cnt - 4'd1;
      end
   end

   always_comb begin
      w_next   = S_FETCH;
      w_pcwr   = 1'b0;
      w_irwr   = 1'b0;
      w_grfwr  = 1'b0;
      w_dmwr   = 1'b0;
      w_npcop  = NPC_PC4;
      w_npcimm = NPCIMM_EXT;
      w_a3     = A3_RT;
      w_wd     = WD_ALU;
      w_alub   = ALUB_EXT;
      w_aluop  = ALU_ADD;
      w_extop  = EXT_ZERO;

      // ALU result is not registered, so its controls stay applied until the instruction retires.
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
         case (w_cls)
            C_ADDU: w_alub = ALUB_RD2;
            C_SUBU: begin w_alub = ALUB_RD2; w_aluop = ALU_SUB; end
            C_ORI:  w_aluop = ALU_OR;
            C_LW,
            C_SW:   w_extop = EXT_SIGN;
            C_BEQ:  begin w_alub = ALUB_RD2; w_aluop = ALU_SUB; w_extop = EXT_SIGN; end
            C_LUI:  w_extop = EXT_LUI;
            default: ;
         endcase
      end

      case (r_state)
         S_FETCH: begin
            w_irwr = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            case (w_cls)
               C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ: w_next = S_EXEC;
               C_LUI, C_JAL: w_next = S_WB;
               C_J: begin
                  w_pcwr   = 1'b1;
                  w_npcop  = NPC_ABS;
                  w_npcimm = NPCIMM_IDX;
               end
               C_JR: begin
                  w_pcwr   = 1'b1;
                  w_npcop  = NPC_ABS;
                  w_npcimm = NPCIMM_RD1;
               end
               default: w_pcwr = 1'b1;
            endcase
         end
         S_EXEC: begin
            case (w_cls)
               C_LW, C_SW: w_next = S_MEM;
               C_BEQ: begin
                  w_pcwr  = 1'b1;
                  w_npcop = zero ? NPC_BR : NPC_PC4;
               end
               default: w_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (r_mem_cnt != 4'd0) begin
               w_next = S_MEM;
            end else if (w_cls == C_SW) begin
               w_dmwr = 1'b1;
               w_pcwr = 1'b1;
            end else begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            w_grfwr = 1'b1;
            w_pcwr  = 1'b1;
            case (w_cls)
               C_ADDU, C_SUBU: w_a3 = A3_RD;
               C_LW:           w_wd = WD_DM;
               C_LUI:          w_wd = WD_EXT;
               C_JAL: begin
                  w_a3     = A3_RA;
                  w_wd     = WD_PC4;
                  w_npcimm = NPCIMM_IDX;
                  w_npcop  = NPC_ABS;
               end
               default: ;
            endcase
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign PCWr         = w_pcwr  & reset;
   assign IRWr         = w_irwr  & reset;
   assign GRFWr        = w_grfwr & reset;
   assign DMWr         = w_dmwr  & reset;
   assign NPCOp        = w_npcop;
   assign NPCIMM_MUXOp = w_npcimm;
   assign GRFA3_MUXOp  = w_a3;
   assign GRFWD_MUXOp  = w_wd;
   assign ALUB_MUXOp   = w_alub;
   assign ALUOp        = w_aluop;
   assign EXTOp        = w_extop;
   assign state        = r_state;

`ifdef MC_CTRL_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_retire_cnt <= '0;
      else if (w_pcwr)
         r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;
`endif

endmodule
